tdm_chan_scanner: RTL and testbench

//  Parametrised, registered N-channel multiplexer for the baseband sample path.

---
 rtl/tdm_mux_pkg.sv | 18 +
 rtl/rr_next_ch.sv | 36 +++
 rtl/tdm_chan_scanner.sv | 145 ++++++++++++++
 tb/tb_tdm_chan_scanner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the TDM channel scanner.
package tdm_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width of a counter holding 0..dwell-1 (never narrower than one bit).
  function automatic int DWELL_W(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Next set bit of a channel mask strictly above cur, wrapping to the lowest set bit.
module rr_next_ch #(
  parameter  int NCH  = 16,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] cur,
  output logic [SELW-1:0] nxt,
  output logic            wrapped,
  output logic            none
);

  logic [NCH-1:0] w_above;

  function automatic logic [SELW-1:0] lowest_idx(input logic [NCH-1:0] m);
    lowest_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) begin
        lowest_idx = SELW'(i);
      end
    end
  endfunction

  // Candidates strictly above the current pointer.
  always_comb begin
    w_above = '0;
    for (int i = 0; i < NCH; i++) begin
      w_above[i] = mask[i] && (i > int'(cur));
    end
  end

  assign none    = (mask == '0);
  assign wrapped = !none && (w_above == '0);
  assign nxt     = (w_above != '0) ? lowest_idx(w_above) : lowest_idx(mask);

endmodule

// File: rtl/tdm_chan_scanner.sv
// Registered N-channel sample multiplexer with MANUAL select and round-robin SCAN modes,
// presented on a valid/ready output.
module tdm_chan_scanner
  import tdm_mux_pkg::*;
#(
  parameter  int NCH   = 16,
  parameter  int DW    = 8,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [SELW-1:0]   sel_in,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [NCH*DW-1:0] data_in,
  output logic [DW-1:0]     out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_start,
  output logic              sel_err
);

  localparam int              DCW        = DWELL_W(DWELL);
  localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_TOP     = SELW'(NCH - 1);

  state_e          r_state;
  logic [SELW-1:0] r_ptr;
  logic [DCW-1:0]  r_dwell;
  logic            r_seek;
  logic            r_lowest;

  logic            w_bnd, w_acc, w_adv, w_entering, w_sel_ok;
  logic [SELW-1:0] w_find_cur, w_nxt, w_scan_ch, w_load_ch;
  logic            w_wrapped, w_none, w_scan_go, w_scan_fs, w_want_lowest;
  logic [DW-1:0]   w_load_data;

  assign w_bnd      = !out_valid || out_ready;
  assign w_acc      = out_valid && out_ready && (r_state == SCAN);
  assign w_adv      = w_acc && (r_dwell == DWELL_LAST);
  assign w_entering = (r_state != SCAN) || r_seek;
  assign w_sel_ok   = {1'b0, sel_in} < (SELW + 1)'(NCH);
  // Outside a running rotation the finder is asked for the lowest set bit.
  assign w_find_cur = w_entering ? CH_TOP : r_ptr;

  rr_next_ch #(.NCH(NCH)) u_next (
    .mask    (ch_mask),
    .cur     (w_find_cur),
    .nxt     (w_nxt),
    .wrapped (w_wrapped),
    .none    (w_none)
  );

  // Channel, go and frame flag for a SCAN beat issued at this boundary.
  always_comb begin
    w_scan_ch     = r_ptr;
    w_scan_go     = 1'b0;
    w_scan_fs     = 1'b0;
    w_want_lowest = 1'b0;
    if (w_entering) begin
      // Coming from MANUAL restarts at the lowest bit; resuming from IDLE keeps the pointer.
      w_want_lowest = (r_state == MANUAL) || ((r_state == SCAN) && r_lowest);
      w_scan_go     = !w_none;
      w_scan_fs     = 1'b1;
      if (!w_want_lowest && ch_mask[r_ptr]) begin
        w_scan_ch = r_ptr;
      end else begin
        w_scan_ch = w_nxt;
      end
    end else if (w_adv) begin
      w_scan_go = !w_none;
      w_scan_ch = w_none ? r_ptr : w_nxt;
      w_scan_fs = w_wrapped;
    end else begin
      w_scan_go = 1'b1;
    end
  end

  assign w_load_ch   = (mode == MODE_SCAN) ? w_scan_ch : sel_in;
  assign w_load_data = data_in[int'(w_load_ch) * DW +: DW];

  // Run-state FSM, dwell counting and the output beat register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_dwell     <= '0;
      r_seek      <= 1'b0;
      r_lowest    <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      sel_err     <= 1'b0;
    end else if (w_bnd) begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      sel_err     <= 1'b0;
      if (w_acc) begin
        r_dwell <= w_adv ? '0 : r_dwell + 1'b1;
        if (w_adv && !w_none) begin
          r_ptr <= w_nxt;
        end
      end
      if (!en) begin
        r_state <= IDLE;
      end else if (mode == MODE_MANUAL) begin
        r_state <= MANUAL;
        if (w_sel_ok) begin
          out_valid <= 1'b1;
          out_data  <= w_load_data;
          out_ch    <= sel_in;
        end else begin
          sel_err <= 1'b1;
        end
      end else begin
        r_state <= SCAN;
        if (w_entering) begin
          r_dwell  <= '0;
          r_lowest <= w_want_lowest;
        end
        if (w_scan_go) begin
          out_valid   <= 1'b1;
          out_data    <= w_load_data;
          out_ch      <= w_scan_ch;
          frame_start <= w_scan_fs;
          r_ptr       <= w_scan_ch;
          r_seek      <= 1'b0;
        end else begin
          // Empty mask: park until a bit appears; after a failed advance restart from the lowest.
          r_seek <= 1'b1;
          if (w_adv) begin
            r_lowest <= 1'b1;
          end
        end
      end
    end else begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_chan_scanner.sv
// Directed and randomized checks of tdm_chan_scanner against a transaction-level model.
module tb_tdm_chan_scanner;

  localparam int NCH = 16;
  localparam int DW = 8;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [3:0] sel_in = 4'd0;
  logic [15:0] ch_mask = 16'd0;
  logic [127:0] data_in = '0;
  logic [7:0] out_data;
  logic [3:0] out_ch;
  logic out_valid, frame_start, sel_err;

  logic en12 = 1'b0;
  logic [3:0] sel12 = 4'd0;
  logic [11:0] mask12 = 12'd0;
  logic [95:0] data12 = '0;
  logic [7:0] out_data12;
  logic [3:0] out_ch12;
  logic out_valid12, fs12, err12;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the expected output beat and scan bookkeeping.
  int m_active;   // -1 idle, 0 manual, 1 scan
  int m_ptr, m_taken, m_ch;
  bit m_waiting, m_lowest;
  logic m_valid, m_fs, m_err;
  logic [7:0] m_data;

  int exp_seq[13] = '{0, 0, 0, 0, 3, 3, 3, 3, 7, 7, 7, 7, 0};

  always #5 clk = ~clk;

  tdm_chan_scanner #(.NCH(16), .DW(8), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .ch_mask(ch_mask),
    .data_in(data_in), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .frame_start(frame_start), .sel_err(sel_err)
  );

  tdm_chan_scanner #(.NCH(12), .DW(8), .DWELL(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .en(en12), .mode(1'b0), .sel_in(sel12), .ch_mask(mask12),
    .data_in(data12), .out_data(out_data12), .out_ch(out_ch12), .out_valid(out_valid12),
    .out_ready(1'b1), .frame_start(fs12), .sel_err(err12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_set(input logic [15:0] m);
    for (int i = 0; i < NCH; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int next_after(input logic [15:0] m, input int p);
    for (int k = 1; k <= NCH; k++) if (m[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction

  task automatic model_reset();
    m_active = -1; m_ptr = 0; m_taken = 0; m_ch = 0;
    m_waiting = 1'b0; m_lowest = 1'b0;
    m_valid = 1'b0; m_fs = 1'b0; m_err = 1'b0; m_data = 8'd0;
  endtask

  task automatic model_load(input int ch, input logic fs);
    m_valid = 1'b1; m_ch = ch; m_fs = fs;
    m_data = data_in[ch*DW +: DW];
  endtask

  // One clock of expected behaviour from the inputs currently applied.
  task automatic model_step();
    int prev, n, pick;
    bit adv, wrap, want_lowest;
    if (m_valid && !out_ready) begin
      m_err = 1'b0;
      return;
    end
    prev = m_active; adv = 1'b0; wrap = 1'b0; n = -1;
    if (m_valid && out_ready && prev == 1) begin
      m_taken++;
      if (m_taken == DWELL) begin
        m_taken = 0; adv = 1'b1;
        n = next_after(ch_mask, m_ptr);
        wrap = (n >= 0) && (n <= m_ptr);
        if (n >= 0) m_ptr = n;
      end
    end
    m_valid = 1'b0; m_fs = 1'b0; m_err = 1'b0;
    if (!en) begin
      m_active = -1;
    end else if (mode == 1'b0) begin
      m_active = 0;
      if (sel_in < NCH) model_load(sel_in, 1'b0);
      else m_err = 1'b1;
    end else begin
      m_active = 1;
      if (prev != 1 || m_waiting) begin
        want_lowest = (prev == 0) || (prev == 1 && m_lowest);
        m_taken = 0; m_lowest = want_lowest;
        pick = (!want_lowest && ch_mask[m_ptr]) ? m_ptr : lowest_set(ch_mask);
        if (pick < 0) m_waiting = 1'b1;
        else begin m_waiting = 1'b0; m_ptr = pick; model_load(pick, 1'b1); end
      end else if (adv) begin
        if (n < 0) begin m_waiting = 1'b1; m_lowest = 1'b1; end
        else model_load(m_ptr, wrap);
      end else begin
        model_load(m_ptr, 1'b0);
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_valid);
    chk("frame_start", frame_start, m_fs);
    chk("sel_err", sel_err, m_err);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_ch", out_ch, m_ch);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0); chk("rst_ch", out_ch, 0);
    chk("rst_fs", frame_start, 0); chk("rst_err", sel_err, 0);
    rst_n = 1'b1;

    // Manual select of channel 5
    en = 1'b1; mode = 1'b0; sel_in = 4'd5; out_ready = 1'b1;
    data_in = '0; data_in[5*8 +: 8] = 8'hA5;
    cycle();
    chk("t1_valid", out_valid, 1); chk("t1_data", out_data, 8'hA5); chk("t1_ch", out_ch, 5);

    // Stalled beat holds while the source keeps changing
    sel_in = 4'd3; data_in[3*8 +: 8] = 8'h11;
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in[3*8 +: 8] = 8'(8'h20 + i);
      cycle();
      chk("t2_hold", out_data, 8'h11);
    end
    out_ready = 1'b1; data_in[3*8 +: 8] = 8'h55;
    cycle();
    chk("t2_release", out_data, 8'h55);

    // Highest legal index on 16 channels, out-of-range index on 12 channels
    sel_in = 4'hF; data_in[15*8 +: 8] = 8'h3C;
    en12 = 1'b1; sel12 = 4'd13; data12 = '0; data12[2*8 +: 8] = 8'h77;
    cycle();
    chk("t5_ch15", out_ch, 15); chk("t5_err16", sel_err, 0);
    chk("t5_err12", err12, 1); chk("t5_valid12", out_valid12, 0);
    sel12 = 4'd2;
    cycle();
    chk("t5_err12_clr", err12, 0); chk("t5_valid12_ok", out_valid12, 1);
    chk("t5_data12", out_data12, 8'h77);
    en12 = 1'b0;

    // Scan rotation over channels 0, 3, 7
    mode = 1'b1; ch_mask = 16'h0089;
    for (int b = 0; b < 13; b++) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      chk("t3_ch", out_ch, exp_seq[b]);
      chk("t3_fs", frame_start, (b == 0 || b == 12) ? 1 : 0);
    end

    // Empty mask issues nothing; a single channel then repeats
    mode = 1'b0; sel_in = 4'd1;
    cycle();
    mode = 1'b1; ch_mask = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_idle", out_valid, 0);
    end
    ch_mask = 16'h0400;
    for (int b = 0; b < 12; b++) begin
      cycle();
      chk("t4_ch", out_ch, 10);
      chk("t4_fs", frame_start, (b % 4 == 0) ? 1 : 0);
    end

    // Asynchronous reset with a stalled scan beat
    ch_mask = 16'h00FF;
    cycle(); cycle();
    out_ready = 1'b0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0); chk("t6_data", out_data, 0); chk("t6_ch", out_ch, 0);
    chk("t6_fs", frame_start, 0); chk("t6_err", sel_err, 0);
    model_reset();
    #1 rst_n = 1'b1;
    en = 1'b0; out_ready = 1'b1;
    cycle();
    en = 1'b1; mode = 1'b1; ch_mask = 16'h00F0;
    cycle();
    chk("t6_resume_ch", out_ch, 4); chk("t6_resume_fs", frame_start, 1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: ch_mask = 16'h0000;
          1: ch_mask = 16'h0001 << $urandom_range(0, 15);
          default: ch_mask = 16'($urandom);
        endcase
      end
      sel_in = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      data_in = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
